// File: rtl/full_adder_rtl_if.sv
// Signal bundle for the full-adder leaf cell: operand inputs, the
// combinational result, the registered result and the debug observables.
interface full_adder_rtl_if #(
  parameter int CNT_W = 8
);
  logic             a;
  logic             b;
  logic             cin;
  logic             sum;
  logic             cout;
  logic             sum_q;
  logic             cout_q;
  logic [CNT_W-1:0] carry_cnt;
  logic             chk_err;

  // Stimulus side: drives operands, observes every result.
  modport master (
    output a, b, cin,
    input  sum, cout, sum_q, cout_q, carry_cnt, chk_err
  );

  // Adder side: consumes operands, produces every result.
  modport slave (
    input  a, b, cin,
    output sum, cout, sum_q, cout_q, carry_cnt, chk_err
  );
endinterface

// File: rtl/full_adder_rtl.sv
// 1-bit full adder leaf cell. sum/cout are purely combinational; a
// registered copy, a saturating carry-event counter and a sticky
// self-consistency flag are provided for pipelined use and debug.
module full_adder_rtl #(
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  full_adder_rtl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       gate_res;   // {cout,sum} from the gate equations
  logic [1:0]       tt_res;     // {cout,sum} from the lookup table
  logic             sum_pipe_q, sum_pipe_d;
  logic             cout_pipe_q, cout_pipe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Gate-level equations; X/Z on inputs propagates naturally.
  assign gate_res[0] = bus.a ^ bus.b ^ bus.cin;
  assign gate_res[1] = (bus.a & bus.b) | (bus.cin & (bus.a ^ bus.b));

  assign bus.sum  = gate_res[0];
  assign bus.cout = gate_res[1];

  // Independent truth-table evaluation used only for the consistency check.
  always_comb begin
    tt_res = 2'bxx;
    case ({bus.a, bus.b, bus.cin})
      3'b000:  tt_res = 2'b00;
      3'b001:  tt_res = 2'b01;
      3'b010:  tt_res = 2'b01;
      3'b011:  tt_res = 2'b10;
      3'b100:  tt_res = 2'b01;
      3'b101:  tt_res = 2'b10;
      3'b110:  tt_res = 2'b10;
      3'b111:  tt_res = 2'b11;
      default: tt_res = 2'bxx;
    endcase
  end

  // Next-state: pipeline copy, saturating carry count, sticky mismatch.
  // An unknown comparison (inputs not all known) evaluates false and
  // leaves the flag alone.
  always_comb begin
    sum_pipe_d  = gate_res[0];
    cout_pipe_d = gate_res[1];
    cnt_d       = cnt_q;
    err_d       = err_q;
    if (gate_res[1] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (gate_res != tt_res) begin
      err_d = 1'b1;
    end
  end

  // State registers; reset wins over any update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_pipe_q  <= 1'b0;
      cout_pipe_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      sum_pipe_q  <= sum_pipe_d;
      cout_pipe_q <= cout_pipe_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.sum_q     = sum_pipe_q;
  assign bus.cout_q    = cout_pipe_q;
  assign bus.carry_cnt = cnt_q;
  assign bus.chk_err   = err_q;

endmodule

// File: tb/tb_full_adder_rtl.sv
// Scoreboard bench for full_adder_rtl: stimulus pushes expected results,
// a monitor pops and compares one entry after each rising edge. Two
// instances share stimulus: CNT_W=8 and CNT_W=2 (for saturation).
module tb_full_adder_rtl;

  typedef struct {
    logic       s;    // expected combinational sum
    logic       c;    // expected combinational cout
    logic       sq;   // expected sum_q after the edge
    logic       cq;   // expected cout_q after the edge
    logic [7:0] c8;   // expected carry_cnt, CNT_W=8 instance
    logic [1:0] c2;   // expected carry_cnt, CNT_W=2 instance
  } exp_t;

  logic clk;
  logic clk_en;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb_q[$];
  logic [1:0] tt [8];   // {cout,sum} hand-written truth table

  full_adder_rtl_if #(.CNT_W(8)) bus8 ();
  full_adder_rtl_if #(.CNT_W(2)) bus2 ();

  full_adder_rtl #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  full_adder_rtl #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    bus8.a = v[2]; bus8.b = v[1]; bus8.cin = v[0];
    bus2.a = v[2]; bus2.b = v[1]; bus2.cin = v[0];
  endtask

  // One clock of stimulus: inputs change on the falling edge, the expected
  // state after the following rising edge goes onto the scoreboard.
  task automatic step(input logic [2:0] v, input logic r,
                      input logic [7:0] e8, input logic [1:0] e2);
    exp_t e;
    logic [1:0] t;
    @(negedge clk);
    rst = r;
    drive(v);
    t    = tt[v];
    e.s  = t[0];
    e.c  = t[1];
    e.sq = r ? 1'b0 : t[0];
    e.cq = r ? 1'b0 : t[1];
    e.c8 = e8;
    e.c2 = e2;
    sb_q.push_back(e);
  endtask

  // Monitor: compare everything the DUTs present just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        $display("txn t=%0t in=%b%b%b rst=%b sum=%b cout=%b sum_q=%b cout_q=%b cnt8=%0d cnt2=%0d err=%b%b",
                 $time, bus8.a, bus8.b, bus8.cin, rst, bus8.sum, bus8.cout, bus8.sum_q,
                 bus8.cout_q, bus8.carry_cnt, bus2.carry_cnt, bus8.chk_err, bus2.chk_err);
        check("sum",        32'(bus8.sum),       32'(e.s));
        check("cout",       32'(bus8.cout),      32'(e.c));
        check("sum_q",      32'(bus8.sum_q),     32'(e.sq));
        check("cout_q",     32'(bus8.cout_q),    32'(e.cq));
        check("carry_cnt8", 32'(bus8.carry_cnt), 32'(e.c8));
        check("carry_cnt2", 32'(bus2.carry_cnt), 32'(e.c2));
        check("chk_err8",   32'(bus8.chk_err),   32'(0));
        check("chk_err2",   32'(bus2.chk_err),   32'(0));
        check("sum_q2",     32'(bus2.sum_q),     32'(e.sq));
      end
    end
  end

  initial begin
    logic [7:0] m8;
    logic [1:0] m2;
    logic [2:0] v;
    logic [1:0] t;
    checks   = 0;
    failures = 0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
    tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;
    drive(3'b000);

    // 1: combinational sweep with the clock stopped
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v);
      #5;
      t = tt[i];
      $display("comb in=%b cout=%b sum=%b", v, bus8.cout, bus8.sum);
      check("comb_sum",  32'(bus8.sum),  32'(t[0]));
      check("comb_cout", 32'(bus8.cout), 32'(t[1]));
      #5;
    end

    clk_en = 1'b1;

    // 2: latency through reset and release
    step(3'b101, 1'b1, 8'd0, 2'd0);
    step(3'b101, 1'b1, 8'd0, 2'd0);
    step(3'b101, 1'b0, 8'd1, 2'd1);   // sum_q=0, cout_q=1
    step(3'b000, 1'b0, 8'd1, 2'd1);

    // 3: carry counter 1,2,2,3
    step(3'b000, 1'b1, 8'd0, 2'd0);
    step(3'b011, 1'b0, 8'd1, 2'd1);
    step(3'b110, 1'b0, 8'd2, 2'd2);
    step(3'b000, 1'b0, 8'd2, 2'd2);
    step(3'b111, 1'b0, 8'd3, 2'd3);

    // 4: saturation (2-bit counter sticks at 3)
    step(3'b000, 1'b1, 8'd0, 2'd0);
    step(3'b110, 1'b0, 8'd1, 2'd1);
    step(3'b110, 1'b0, 8'd2, 2'd2);
    step(3'b110, 1'b0, 8'd3, 2'd3);
    step(3'b110, 1'b0, 8'd4, 2'd3);
    step(3'b110, 1'b0, 8'd5, 2'd3);
    step(3'b110, 1'b0, 8'd6, 2'd3);

    // 5: reset mid-operation with all inputs high
    step(3'b000, 1'b1, 8'd0, 2'd0);
    step(3'b111, 1'b0, 8'd1, 2'd1);
    step(3'b111, 1'b0, 8'd2, 2'd2);
    step(3'b111, 1'b0, 8'd3, 2'd3);   // cnt=3, sum_q=1
    step(3'b111, 1'b1, 8'd0, 2'd0);   // cleared, comb still 1/1

    // 6: random operands against a saturating reference count
    m8 = 8'd0;
    m2 = 2'd0;
    for (int n = 0; n < 1000; n++) begin
      v = 3'($urandom_range(0, 7));
      t = tt[v];
      if (t[1]) begin
        if (m8 != 8'hFF) m8 = m8 + 8'd1;
        if (m2 != 2'd3)  m2 = m2 + 2'd1;
      end
      step(v, 1'b0, m8, m2);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
